// File: rtl/conv_stream_fifo_pkg.sv
// Shared constants for the convolution-to-DMA stream path: default widths, frame length and helpers.
package conv_stream_fifo_pkg;

   localparam int unsigned CONV_DATA_W    = 20;
   localparam int unsigned AXIS_DATA_W    = 32;
   localparam int unsigned CONV_FRAME_LEN = 676;

   // Index width for a counter/pointer over n entries; never narrower than one bit.
   function automatic int unsigned addr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_stream_if.sv
// Stream bus between convolution engine, FIFO and output DMA: write valid/ready plus read valid/ready/last.
interface conv_stream_if
   import conv_stream_fifo_pkg::*;
#(
   parameter int unsigned DATA_IN_W  = CONV_DATA_W,
   parameter int unsigned DATA_OUT_W = AXIS_DATA_W
) ();

   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_IN_W-1:0]  s_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_OUT_W-1:0] m_data;
   logic                  m_last;

   // FIFO side: receives writes, sources output words
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );

   // Environment side: producer on the write port, consumer on the read port
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

endinterface

// File: rtl/conv_fifo_ram.sv
// Simple dual-port RAM, synchronous write and enabled synchronous read, for block-RAM inference.
module conv_fifo_ram
   import conv_stream_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WIDTH = CONV_DATA_W,
   parameter int unsigned AW    = addr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Output register doubles as the FIFO output word; its reset gives m_data = 0.
   always_ff @(posedge clk) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/conv_stream_fifo.sv
// Convolution result FIFO with registered, width-extended AXI-Stream style output and frame-end marker.
// Optional peak occupancy output enabled by defining CONV_STREAM_FIFO_HWM_EN.
module conv_stream_fifo
   import conv_stream_fifo_pkg::*;
#(
   parameter int unsigned DATA_IN_W  = CONV_DATA_W,
   parameter int unsigned DATA_OUT_W = AXIS_DATA_W,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned FRAME_LEN  = CONV_FRAME_LEN,
   parameter int unsigned AFULL_TH   = 1000,
   parameter int unsigned AEMPTY_TH  = 4,
   parameter int unsigned SIGNED     = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   conv_stream_if.slave               bus,
   output logic [$clog2(DEPTH+2)-1:0] count,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clear_err
`ifdef CONV_STREAM_FIFO_HWM_EN
   ,
   output logic [$clog2(DEPTH+2)-1:0] hwm
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH+2);
   localparam int unsigned AW    = addr_w(DEPTH);
   localparam int unsigned FW    = addr_w(FRAME_LEN);

   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     ram_cnt, ram_cnt_nx, count_nx;
   logic [FW-1:0]        frame_cnt, frame_cnt_nx;
   logic                 s_ready_q, m_valid_q, m_last_q, m_valid_nx;
   logic                 wr, rd_en, hs;
   logic [DATA_IN_W-1:0] ram_q;

   conv_fifo_ram #(.DEPTH(DEPTH), .WIDTH(DATA_IN_W), .AW(AW)) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr),
      .waddr (wr_ptr),
      .wdata (bus.s_data),
      .re    (rd_en),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );

   // Next-state: handshakes, RAM occupancy, output-register valid and frame position
   always_comb begin
      wr           = bus.s_valid & s_ready_q;
      rd_en        = (ram_cnt != '0) & (~m_valid_q | bus.m_ready);
      hs           = m_valid_q & bus.m_ready;
      ram_cnt_nx   = ram_cnt;
      m_valid_nx   = m_valid_q;
      frame_cnt_nx = frame_cnt;
      if (wr & ~rd_en)      ram_cnt_nx = ram_cnt + CNT_W'(1);
      else if (rd_en & ~wr) ram_cnt_nx = ram_cnt - CNT_W'(1);
      if (rd_en)   m_valid_nx = 1'b1;
      else if (hs) m_valid_nx = 1'b0;
      if (hs) frame_cnt_nx = (frame_cnt == FW'(FRAME_LEN-1)) ? '0 : frame_cnt + FW'(1);
      count_nx = ram_cnt_nx + CNT_W'(m_valid_nx);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         ram_cnt      <= '0;
         frame_cnt    <= '0;
         s_ready_q    <= 1'b1;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         count        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr)    wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
         ram_cnt      <= ram_cnt_nx;
         frame_cnt    <= frame_cnt_nx;
         m_valid_q    <= m_valid_nx;
         m_last_q     <= m_valid_nx & (frame_cnt_nx == FW'(FRAME_LEN-1));
         s_ready_q    <= (ram_cnt_nx != CNT_W'(DEPTH));
         count        <= count_nx;
         almost_full  <= (32'(count_nx) >= AFULL_TH);
         almost_empty <= (32'(count_nx) <= AEMPTY_TH);
         // Clear wins over a simultaneous error event
         if (clear_err)                        overflow <= 1'b0;
         else if (bus.s_valid & ~s_ready_q)    overflow <= 1'b1;
         if (clear_err)                                        underflow <= 1'b0;
         else if (bus.m_ready & ~m_valid_q & (ram_cnt == '0))  underflow <= 1'b1;
      end
   end

`ifdef CONV_STREAM_FIFO_HWM_EN
   always_ff @(posedge clk) begin
      if (reset || clear_err) hwm <= '0;
      else if (count > hwm)   hwm <= count;
   end
`endif

   assign bus.s_ready = s_ready_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_last  = m_last_q;

   generate
      if (SIGNED != 0) begin : g_sext
         assign bus.m_data = DATA_OUT_W'($signed(ram_q));
      end else begin : g_zext
         assign bus.m_data = DATA_OUT_W'(ram_q);
      end
   endgenerate

endmodule

// File: tb/tb_conv_stream_fifo.sv
// Directed bench for conv_stream_fifo: instance a (DEPTH 8, FRAME_LEN 4, signed) and b (DEPTH 6, unsigned).
module tb_conv_stream_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, reset_b, clear_a, clear_b;
   logic [3:0] count_a;
   logic [2:0] count_b;
   logic       afull_a, aempty_a, ovf_a, udf_a;
   logic       afull_b, aempty_b, ovf_b, udf_b;
`ifdef CONV_STREAM_FIFO_HWM_EN
   logic [3:0] hwm_a;
   logic [2:0] hwm_b;
`endif

   int checks = 0;
   int errors = 0;

   conv_stream_if #(.DATA_IN_W(20), .DATA_OUT_W(32)) bus_a ();
   conv_stream_if #(.DATA_IN_W(20), .DATA_OUT_W(32)) bus_b ();

   conv_stream_fifo #(
      .DATA_IN_W(20), .DATA_OUT_W(32), .DEPTH(8), .FRAME_LEN(4),
      .AFULL_TH(7), .AEMPTY_TH(2), .SIGNED(1)
   ) dut_a (
      .clk(clk), .reset(reset_a), .bus(bus_a), .count(count_a),
      .almost_full(afull_a), .almost_empty(aempty_a),
      .overflow(ovf_a), .underflow(udf_a), .clear_err(clear_a)
`ifdef CONV_STREAM_FIFO_HWM_EN
      , .hwm(hwm_a)
`endif
   );

   conv_stream_fifo #(
      .DATA_IN_W(20), .DATA_OUT_W(32), .DEPTH(6), .FRAME_LEN(676),
      .AFULL_TH(5), .AEMPTY_TH(1), .SIGNED(0)
   ) dut_b (
      .clk(clk), .reset(reset_b), .bus(bus_b), .count(count_b),
      .almost_full(afull_b), .almost_empty(aempty_b),
      .overflow(ovf_b), .underflow(udf_b), .clear_err(clear_b)
`ifdef CONV_STREAM_FIFO_HWM_EN
      , .hwm(hwm_b)
`endif
   );

   // Input patterns, alternating sign on a, MSB set on b
   function automatic logic [19:0] pat_a(input int i);
      return (i % 2 == 1) ? 20'h8A5A0 + 20'(i) : 20'h05A5F + 20'(i * 16);
   endfunction
   function automatic logic [19:0] pat_b(input int i);
      return 20'hA0000 + 20'(i * 20'h00357);
   endfunction
   function automatic logic [31:0] sext(input logic [19:0] d);
      return {{12{d[19]}}, d};
   endfunction

   task automatic do_reset_a();
      reset_a = 1'b1;
      @(negedge clk);
      reset_a = 1'b0;
   endtask

   task automatic test_reset();
      reset_a = 1'b1; reset_b = 1'b1;
      repeat (2) @(negedge clk);
      reset_a = 1'b0; reset_b = 1'b0;
      checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b exp 0", bus_a.m_valid); end
      checks++; if (bus_a.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b exp 0", bus_a.m_last); end
      checks++; if (bus_a.m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h exp 0", bus_a.m_data); end
      checks++; if (bus_a.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b exp 1", bus_a.s_ready); end
      checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count_a); end
      checks++; if (aempty_a !== 1'b1 || afull_a !== 1'b0) begin errors++; $display("FAIL reset_thresholds: got ae=%b af=%b exp ae=1 af=0", aempty_a, afull_a); end
      checks++; if (ovf_a !== 1'b0 || udf_a !== 1'b0) begin errors++; $display("FAIL reset_sticky: got ovf=%b udf=%b exp 0 0", ovf_a, udf_a); end
      checks++; if (bus_b.m_valid !== 1'b0 || bus_b.s_ready !== 1'b1 || count_b !== 3'd0) begin errors++; $display("FAIL reset_b: got mv=%b sr=%b cnt=%0d exp 0 1 0", bus_b.m_valid, bus_b.s_ready, count_b); end
   endtask

   task automatic test_sign_ext();
      bus_a.s_valid = 1'b1; bus_a.s_data = 20'hFFFFF;
      @(negedge clk);
      bus_a.s_valid = 1'b0;
      checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL sext_latency_early: got m_valid=%b exp 0", bus_a.m_valid); end
      @(negedge clk);
      checks++; if (bus_a.m_valid !== 1'b1) begin errors++; $display("FAIL sext_latency: got m_valid=%b exp 1", bus_a.m_valid); end
      checks++; if (bus_a.m_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL sext_data: got %h exp ffffffff", bus_a.m_data); end
      checks++; if (count_a !== 4'd1) begin errors++; $display("FAIL sext_count: got %0d exp 1", count_a); end
      bus_a.m_ready = 1'b1;
      @(negedge clk);
      bus_a.m_ready = 1'b0;
      checks++; if (bus_a.m_valid !== 1'b0 || count_a !== 4'd0) begin errors++; $display("FAIL sext_drain: got mv=%b cnt=%0d exp 0 0", bus_a.m_valid, count_a); end
   endtask

   task automatic test_zero_ext();
      bus_b.s_valid = 1'b1; bus_b.s_data = 20'hFFFFF;
      @(negedge clk);
      bus_b.s_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus_b.m_valid !== 1'b1 || bus_b.m_data !== 32'h000FFFFF) begin errors++; $display("FAIL zext_data: got mv=%b %h exp 1 000fffff", bus_b.m_valid, bus_b.m_data); end
      bus_b.m_ready = 1'b1;
      @(negedge clk);
      bus_b.m_ready = 1'b0;
      checks++; if (bus_b.m_valid !== 1'b0 || count_b !== 3'd0) begin errors++; $display("FAIL zext_drain: got mv=%b cnt=%0d exp 0 0", bus_b.m_valid, count_b); end
   endtask

   task automatic test_underflow();
      do_reset_a();
      bus_a.m_ready = 1'b1;
      @(negedge clk);
      bus_a.m_ready = 1'b0;
      checks++; if (udf_a !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b exp 1", udf_a); end
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      checks++; if (udf_a !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b exp 0", udf_a); end
   endtask

   task automatic fill_a();
      for (int i = 0; i < 9; i++) begin
         bus_a.s_valid = 1'b1; bus_a.s_data = pat_a(i);
         @(negedge clk);
         checks++; if (count_a !== 4'(i + 1)) begin errors++; $display("FAIL fill_count_%0d: got %0d exp %0d", i, count_a, i + 1); end
         checks++; if (aempty_a !== (i + 1 <= 2) || afull_a !== (i + 1 >= 7)) begin errors++; $display("FAIL fill_thresh_%0d: got ae=%b af=%b", i, aempty_a, afull_a); end
      end
      bus_a.s_valid = 1'b0;
   endtask

   task automatic test_fill_overflow();
      int rx;
      int guard;
      do_reset_a();
      fill_a();
      checks++; if (bus_a.s_ready !== 1'b0 || ovf_a !== 1'b0) begin errors++; $display("FAIL full_state: got sr=%b ovf=%b exp 0 0", bus_a.s_ready, ovf_a); end
      bus_a.s_valid = 1'b1; bus_a.s_data = 20'h0BAD0;
      @(negedge clk);
      bus_a.s_valid = 1'b0;
      checks++; if (ovf_a !== 1'b1 || count_a !== 4'd9) begin errors++; $display("FAIL overflow_drop: got ovf=%b cnt=%0d exp 1 9", ovf_a, count_a); end
      bus_a.m_ready = 1'b1;
      rx = 0; guard = 0;
      while (rx < 9 && guard < 30) begin
         if (bus_a.m_valid) begin
            checks++; if (bus_a.m_data !== sext(pat_a(rx))) begin errors++; $display("FAIL drain_data_%0d: got %h exp %h", rx, bus_a.m_data, sext(pat_a(rx))); end
            rx++;
         end
         @(negedge clk);
         guard++;
      end
      bus_a.m_ready = 1'b0;
      checks++; if (rx !== 9 || bus_a.m_valid !== 1'b0 || count_a !== 4'd0) begin errors++; $display("FAIL drain_end: got rx=%0d mv=%b cnt=%0d exp 9 0 0", rx, bus_a.m_valid, count_a); end
   endtask

   task automatic test_back_to_back();
      int tx, rx, first;
      tx = 0; rx = 0; first = -1;
      bus_b.m_ready = 1'b1;
      for (int c = 0; c < 60 && rx < 18; c++) begin
         if (bus_b.m_valid) begin
            if (first < 0) first = c;
            checks++; if (bus_b.m_data !== {12'h0, pat_b(rx)}) begin errors++; $display("FAIL b2b_data_%0d: got %h exp %h", rx, bus_b.m_data, {12'h0, pat_b(rx)}); end
            rx++;
         end else if (rx > 0) begin
            checks++; errors++; $display("FAIL b2b_bubble: got m_valid=0 at word %0d exp 1", rx);
         end
         bus_b.s_valid = (tx < 18);
         bus_b.s_data  = pat_b(tx);
         if (bus_b.s_valid && bus_b.s_ready) tx++;
         @(negedge clk);
      end
      bus_b.s_valid = 1'b0; bus_b.m_ready = 1'b0;
      checks++; if (first !== 2) begin errors++; $display("FAIL b2b_first_latency: got cycle %0d exp 2", first); end
      checks++; if (rx !== 18 || count_b !== 3'd0) begin errors++; $display("FAIL b2b_total: got rx=%0d cnt=%0d exp 18 0", rx, count_b); end
   endtask

   task automatic test_frame_last();
      int tx, rx, lasts;
      logic mr, prev_stall, prev_last;
      logic [31:0] prev_data;
      do_reset_a();
      tx = 0; rx = 0; lasts = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
      for (int c = 0; c < 200 && rx < 10; c++) begin
         if (prev_stall) begin
            checks++; if (bus_a.m_data !== prev_data || bus_a.m_last !== prev_last) begin errors++; $display("FAIL stall_hold: got %h/%b exp %h/%b", bus_a.m_data, bus_a.m_last, prev_data, prev_last); end
         end
         mr = 1'($urandom_range(0, 1));
         bus_a.m_ready = mr;
         if (bus_a.m_valid && mr) begin
            rx++;
            if (bus_a.m_last) lasts++;
            checks++; if (bus_a.m_last !== (rx == 4 || rx == 8)) begin errors++; $display("FAIL frame_last_word%0d: got %b exp %b", rx, bus_a.m_last, (rx == 4 || rx == 8)); end
            checks++; if (bus_a.m_data !== sext(pat_a(rx - 1))) begin errors++; $display("FAIL frame_data_word%0d: got %h exp %h", rx, bus_a.m_data, sext(pat_a(rx - 1))); end
         end
         prev_stall = bus_a.m_valid & ~mr;
         prev_data  = bus_a.m_data;
         prev_last  = bus_a.m_last;
         bus_a.s_valid = (tx < 10);
         bus_a.s_data  = pat_a(tx);
         if (bus_a.s_valid && bus_a.s_ready) tx++;
         @(negedge clk);
      end
      bus_a.s_valid = 1'b0; bus_a.m_ready = 1'b0;
      checks++; if (rx !== 10 || lasts !== 2) begin errors++; $display("FAIL frame_total: got rx=%0d lasts=%0d exp 10 2", rx, lasts); end
   endtask

   task automatic test_reset_mid_frame();
      int rx;
      do_reset_a();
      for (int i = 0; i < 6; i++) begin
         bus_a.s_valid = 1'b1; bus_a.s_data = pat_a(i);
         @(negedge clk);
      end
      bus_a.s_valid = 1'b0;
      bus_a.m_ready = 1'b1;
      @(negedge clk);
      bus_a.m_ready = 1'b0;
      checks++; if (count_a !== 4'd5) begin errors++; $display("FAIL midframe_buffered: got %0d exp 5", count_a); end
      reset_a = 1'b1;
      @(negedge clk);
      reset_a = 1'b0;
      checks++; if (bus_a.m_valid !== 1'b0 || count_a !== 4'd0 || bus_a.s_ready !== 1'b1) begin errors++; $display("FAIL midframe_reset: got mv=%b cnt=%0d sr=%b exp 0 0 1", bus_a.m_valid, count_a, bus_a.s_ready); end
      for (int i = 0; i < 4; i++) begin
         bus_a.s_valid = 1'b1; bus_a.s_data = pat_a(i + 20);
         @(negedge clk);
      end
      bus_a.s_valid = 1'b0;
      @(negedge clk);
      bus_a.m_ready = 1'b1;
      rx = 0;
      for (int c = 0; c < 10 && rx < 4; c++) begin
         if (bus_a.m_valid) begin
            checks++; if (bus_a.m_data !== sext(pat_a(rx + 20)) || bus_a.m_last !== (rx == 3)) begin errors++; $display("FAIL midframe_after_%0d: got %h/%b exp %h/%b", rx, bus_a.m_data, bus_a.m_last, sext(pat_a(rx + 20)), (rx == 3)); end
            rx++;
         end
         @(negedge clk);
      end
      bus_a.m_ready = 1'b0;
      checks++; if (rx !== 4) begin errors++; $display("FAIL midframe_count: got %0d words exp 4", rx); end
   endtask

   task automatic test_clear_err();
      do_reset_a();
      fill_a();
      @(negedge clk);
`ifdef CONV_STREAM_FIFO_HWM_EN
      checks++; if (hwm_a !== 4'd9) begin errors++; $display("FAIL hwm_peak: got %0d exp 9", hwm_a); end
`endif
      bus_a.s_valid = 1'b1; bus_a.s_data = 20'h0BAD1; clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL clear_priority: got ovf=%b exp 0", ovf_a); end
`ifdef CONV_STREAM_FIFO_HWM_EN
      checks++; if (hwm_a !== 4'd0) begin errors++; $display("FAIL hwm_clear: got %0d exp 0", hwm_a); end
`endif
      @(negedge clk);
      bus_a.s_valid = 1'b0;
      checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL overflow_reset_after_clear: got %b exp 1", ovf_a); end
`ifdef CONV_STREAM_FIFO_HWM_EN
      checks++; if (hwm_a !== 4'd9) begin errors++; $display("FAIL hwm_retrack: got %0d exp 9", hwm_a); end
`endif
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b exp 0", ovf_a); end
   endtask

   initial begin
      reset_a = 1'b1; reset_b = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
      bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.m_ready = 1'b0;
      bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.m_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_sign_ext();
      test_zero_ext();
      test_underflow();
      test_fill_overflow();
      test_back_to_back();
      test_frame_last();
      test_reset_mid_frame();
      test_clear_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
